// File: rtl/phase_pwm_pkg.sv
// Shared definitions for the phase PWM generator/monitor pair.
//   PWM_CNT_WIDTH      default width of period/high-time counters
//   PWM_TIMEOUT        default clk ticks without a high-side rise before stuck
//   PWM_MIN_DEAD_TIME  default dead-time fault threshold in clk ticks
//   pwm_mon_state_e    monitor FSM states
package phase_pwm_pkg;

  localparam int PWM_CNT_WIDTH     = 12;
  localparam int PWM_TIMEOUT       = 2048;
  localparam int PWM_MIN_DEAD_TIME = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } pwm_mon_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer with edge decode for one asynchronous gate line.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   async_in    raw gate signal, asynchronous to clk
//   level       synchronized level
//   rise, fall  one-cycle pulses on synchronized edges
// The pulses are decoded purely from flop outputs (never from the first,
// possibly metastable stage), so they are clean one-cycle strobes.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], async_in};
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/phase_pwm_monitor.sv
// Receive-side monitor for one phase's high/low gate pair: measures period
// and high-side on-time, flags stuck PWM and shoot-through, and optionally
// tracks dead time.
// Optional feature: define PHASE_PWM_MON_DEADTIME_EN to build the dead-time
// measurement; otherwise dead_time_min is tied all ones and dead_fault to 0.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          1 = measure; 0 = FSM held in IDLE, results hold
//   pwm_high_in     high-side gate, async
//   pwm_low_in      low-side gate, async
//   fault_clear     pulse, clears sticky fault flags
//   period          last period, ticks rising-to-rising
//   high_time       last high-side on-time, ticks
//   meas_valid      one-cycle strobe when period/high_time update
//   stuck           high while the high side has shown no rise for TIMEOUT
//   stuck_level     synced high-side level when stuck was set
//   shoot_through   sticky, both synced lines high on one cycle
//   dead_time_min   smallest dead time since clear
//   dead_fault      sticky, a dead time below MIN_DEAD_TIME was seen
//
// state | meaning
// IDLE  | disabled or waiting for the first high-side rise
// HIGH  | high side on, period and high-time counters running
// LOW   | high side off, high-time frozen, period counter running
// STUCK | no high-side rise for TIMEOUT ticks
module phase_pwm_monitor
  import phase_pwm_pkg::*;
#(
  parameter int CNT_WIDTH     = PWM_CNT_WIDTH,
  parameter int TIMEOUT       = PWM_TIMEOUT,
  parameter int MIN_DEAD_TIME = PWM_MIN_DEAD_TIME
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pwm_high_in,
  input  logic                 pwm_low_in,
  input  logic                 fault_clear,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic                 stuck_level,
  output logic                 shoot_through,
  output logic [CNT_WIDTH-1:0] dead_time_min,
  output logic                 dead_fault
);

  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

  if (TIMEOUT >= (1 << CNT_WIDTH) || MIN_DEAD_TIME > TIMEOUT) begin : g_param_check
    $error("phase_pwm_monitor: need TIMEOUT < 2**CNT_WIDTH and MIN_DEAD_TIME <= TIMEOUT");
  end

  logic hi_lvl, hi_rise, hi_fall;
  logic lo_lvl, lo_rise, lo_fall;

  pwm_sync_edge u_sync_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_high_in),
    .level    (hi_lvl),
    .rise     (hi_rise),
    .fall     (hi_fall)
  );

  pwm_sync_edge u_sync_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_low_in),
    .level    (lo_lvl),
    .rise     (lo_rise),
    .fall     (lo_fall)
  );

  pwm_mon_state_e       state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d, high_q, high_d;
  logic                 mv_q, mv_d, stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  logic                 shoot_q;
  logic [CNT_WIDTH-1:0] cnt_inc, hcnt_inc;

  assign cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q + ONE;
  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + ONE;

  // cnt restarts at 0 on a rise and period is cnt+1; hcnt restarts at 1 so
  // the rise cycle itself is part of the on-time.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_d      = high_q;
    mv_d        = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else if (state_q != ST_STUCK && cnt_q >= TO_CNT) begin
      // Timeout wins over a coincident rise: that period exceeded TIMEOUT.
      state_d     = ST_STUCK;
      stuck_d     = 1'b1;
      stuck_lvl_d = hi_lvl;
      period_d    = '0;
      high_d      = {CNT_WIDTH{hi_lvl}};
      mv_d        = 1'b1;
    end else if (hi_rise) begin
      state_d = ST_HIGH;
      cnt_d   = '0;
      hcnt_d  = ONE;
      stuck_d = 1'b0;
      if (state_q == ST_HIGH || state_q == ST_LOW) begin
        period_d = cnt_q + ONE;
        high_d   = hcnt_q;
        mv_d     = 1'b1;
      end
    end else if (state_q == ST_HIGH) begin
      if (hi_fall) state_d = ST_LOW;
      else         hcnt_d  = hcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      mv_q        <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      shoot_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      mv_q        <= mv_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      // A new overlap on the clear cycle keeps the flag set.
      shoot_q     <= (hi_lvl & lo_lvl) | (shoot_q & ~fault_clear);
    end
  end

  assign period        = period_q;
  assign high_time     = high_q;
  assign meas_valid    = mv_q;
  assign stuck         = stuck_q;
  assign stuck_level   = stuck_lvl_q;
  assign shoot_through = shoot_q;

`ifdef PHASE_PWM_MON_DEADTIME_EN
  localparam logic [CNT_WIDTH-1:0] MIN_DT = CNT_WIDTH'(MIN_DEAD_TIME);

  logic                 gap_q, gap_d, gap_hi_q, gap_hi_d;
  logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d, dmin_q, dmin_d, dmin_base;
  logic                 rec;
  logic [CNT_WIDTH-1:0] rec_val;
  logic                 dfault_q;

  // A gap opens on one side's fall with the other side low and closes on
  // the opposite side's rise; the same side re-rising abandons it.
  always_comb begin
    gap_d    = gap_q;
    gap_hi_d = gap_hi_q;
    dcnt_d   = dcnt_q;
    rec      = 1'b0;
    rec_val  = '0;
    if ((hi_fall && lo_rise) || (lo_fall && hi_rise)) begin
      rec   = 1'b1;
      gap_d = 1'b0;
    end else if (hi_fall && !lo_lvl) begin
      gap_d    = 1'b1;
      gap_hi_d = 1'b1;
      dcnt_d   = ONE;
    end else if (lo_fall && !hi_lvl) begin
      gap_d    = 1'b1;
      gap_hi_d = 1'b0;
      dcnt_d   = ONE;
    end else if (gap_q) begin
      if (gap_hi_q ? lo_rise : hi_rise) begin
        rec     = 1'b1;
        rec_val = dcnt_q;
        gap_d   = 1'b0;
      end else if (hi_rise || lo_rise) begin
        gap_d = 1'b0;
      end else if (!(&dcnt_q)) begin
        dcnt_d = dcnt_q + ONE;
      end
    end
    dmin_base = fault_clear ? '1 : dmin_q;
    dmin_d    = (rec && rec_val < dmin_base) ? rec_val : dmin_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q    <= 1'b0;
      gap_hi_q <= 1'b0;
      dcnt_q   <= '0;
      dmin_q   <= '1;
      dfault_q <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      gap_hi_q <= gap_hi_d;
      dcnt_q   <= dcnt_d;
      dmin_q   <= dmin_d;
      dfault_q <= (rec && rec_val < MIN_DT) | (dfault_q & ~fault_clear);
    end
  end

  assign dead_time_min = dmin_q;
  assign dead_fault    = dfault_q;
`else
  logic unused_lo_edges;
  assign unused_lo_edges = lo_rise ^ lo_fall;
  assign dead_time_min   = '1;
  assign dead_fault      = 1'b0;
`endif

endmodule
